// File: rtl/seq_divider.sv
// Iterative unsigned restoring divider: one quotient bit per clock, N-cycle RUN phase.
// Results are registered on entry to FIN and held until the next operation completes.
module seq_divider #(
  parameter int unsigned N = 4
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         start,
  input  logic [N-1:0] dividend,
  input  logic [N-1:0] divisor,
  output logic [N-1:0] quotient,
  output logic [N-1:0] remainder,
  output logic         busy,
  output logic         done,
  output logic         div_by_zero
);

  localparam int unsigned CntW = $clog2(N + 1);

  typedef enum logic [1:0] {StIdle, StRun, StFin} state_e;

  state_e          state_q;
  logic [N:0]      a_q;
  logic [N-1:0]    q_q;
  logic [N-1:0]    d_q;
  logic [CntW-1:0] cnt_q;

  logic [2*N:0]    aq_shift;
  logic [N:0]      a_shift;
  logic [N:0]      trial;
  logic [N:0]      a_step;
  logic [N-1:0]    q_step;

  // One restoring step on the current {A,Q}; the MSB of the trial difference is its sign.
  always_comb begin
    aq_shift  = {a_q, q_q} << 1;
    a_shift   = aq_shift[2*N:N];
    trial     = a_shift - {1'b0, d_q};
    q_step    = aq_shift[N-1:0];
    q_step[0] = ~trial[N];
    a_step    = trial[N] ? a_shift : trial;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= StIdle;
      a_q         <= '0;
      q_q         <= '0;
      d_q         <= '0;
      cnt_q       <= '0;
      quotient    <= '0;
      remainder   <= '0;
      busy        <= 1'b0;
      done        <= 1'b0;
      div_by_zero <= 1'b0;
    end else begin
      done <= 1'b0;
      unique case (state_q)
        // FIN accepts a new start directly so operations can issue back-to-back.
        StIdle, StFin: begin
          if (start) begin
            a_q   <= '0;
            q_q   <= dividend;
            d_q   <= divisor;
            cnt_q <= CntW'(N);
            if (divisor == '0) begin
              state_q     <= StFin;
              busy        <= 1'b0;
              done        <= 1'b1;
              quotient    <= '1;
              remainder   <= dividend;
              div_by_zero <= 1'b1;
            end else begin
              state_q <= StRun;
              busy    <= 1'b1;
            end
          end else begin
            state_q <= StIdle;
          end
        end
        StRun: begin
          a_q   <= a_step;
          q_q   <= q_step;
          cnt_q <= cnt_q - 1'b1;
          if (cnt_q == CntW'(1)) begin
            state_q     <= StFin;
            busy        <= 1'b0;
            done        <= 1'b1;
            quotient    <= q_step;
            remainder   <= a_step[N-1:0];
            div_by_zero <= 1'b0;
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

endmodule
